gray_rx_decoder: RTL and testbench

Receive-side counterpart of the team's binary-to-Gray counter. It samples a Gray-coded count stream, decodes it back to binary, and checks that successive samples are legal single steps (+1 or hold). It reports lock, wrap and step errors. It sits at the consumer end of a Gray count bus, for example after a CDC synchroniser or at a pointer monitor.

---
 rtl/gray_pkg.sv | 23 ++
 rtl/gray2bin_dec.sv | 19 +
 rtl/gray_rx_decoder.sv | 103 ++++++++++
 tb/tb_gray_rx_decoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code types, defaults and conversion helpers
package gray_pkg;

   localparam int CBITS_DEF    = 8;
   localparam int LOCK_CNT_DEF = 4;

   typedef enum logic {UNLOCKED, LOCKED} state_t;

   // Operate on 32-bit values; narrower codes are zero-extended, which both forms tolerate.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b = '0;
      for (int i = 0; i < 32; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/gray2bin_dec.sv
// rtl/gray2bin_dec.sv - combinational Gray-to-binary decoder
module gray2bin_dec
   import gray_pkg::*;
#(
   parameter int CBITS = CBITS_DEF
) (
   input  logic [CBITS-1:0] gray,
   output logic [CBITS-1:0] bin
);

   // Each binary bit is the parity of all Gray bits at or above it.
   always_comb begin
      bin = '0;
      for (int i = 0; i < CBITS; i++) begin
         bin[i] = ^(gray >> i);
      end
   end

endmodule

// File: rtl/gray_rx_decoder.sv
// rtl/gray_rx_decoder.sv - two-stage Gray count receiver with lock, wrap and step checking
module gray_rx_decoder
   import gray_pkg::*;
#(
   parameter int CBITS    = CBITS_DEF,
   parameter int LOCK_CNT = LOCK_CNT_DEF,
   parameter int ERRW     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CBITS-1:0] gray_in,
   input  logic             gray_vld,
   output logic [CBITS-1:0] bin_out,
   output logic             bin_vld,
   output logic             zero,
   output logic             wrap,
   output logic             step_err,
   output logic             locked,
   output logic [ERRW-1:0]  err_cnt
);

   logic [CBITS-1:0] s1_gray;
   logic             s1_vld;
   logic [CBITS-1:0] dec_bin;
   logic [CBITS-1:0] ref_bin;
   logic             has_ref;
   logic [CBITS-1:0] good_run;
   logic [CBITS-1:0] good_run_nxt;
   logic             is_inc;
   logic             is_hold;
   state_t           state;

   gray2bin_dec #(.CBITS(CBITS)) u_dec (
      .gray (s1_gray),
      .bin  (dec_bin)
   );

   assign is_inc       = has_ref && (dec_bin == ref_bin + CBITS'(1));
   assign is_hold      = has_ref && (dec_bin == ref_bin);
   assign good_run_nxt = good_run + CBITS'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_gray  <= '0;
         s1_vld   <= 1'b0;
         ref_bin  <= '0;
         has_ref  <= 1'b0;
         good_run <= '0;
         state    <= UNLOCKED;
         bin_out  <= '0;
         bin_vld  <= 1'b0;
         zero     <= 1'b0;
         wrap     <= 1'b0;
         step_err <= 1'b0;
         locked   <= 1'b0;
         err_cnt  <= '0;
      end else begin
         s1_vld <= gray_vld;
         if (gray_vld) begin
            s1_gray <= gray_in;
         end

         bin_vld  <= s1_vld;
         zero     <= 1'b0;
         wrap     <= 1'b0;
         step_err <= 1'b0;

         if (s1_vld) begin
            bin_out <= dec_bin;
            zero    <= (dec_bin == '0);
            wrap    <= is_inc && (&ref_bin);
            ref_bin <= dec_bin;
            has_ref <= 1'b1;

            // The first sample after reset only seeds the reference.
            if (has_ref) begin
               if (state == UNLOCKED) begin
                  if (is_inc) begin
                     if (good_run_nxt == CBITS'(LOCK_CNT)) begin
                        state    <= LOCKED;
                        locked   <= 1'b1;
                        good_run <= '0;
                     end else begin
                        good_run <= good_run_nxt;
                     end
                  end else if (!is_hold) begin
                     good_run <= '0;
                  end
               end else if (!is_inc && !is_hold) begin
                  step_err <= 1'b1;
                  state    <= UNLOCKED;
                  locked   <= 1'b0;
                  good_run <= '0;
                  if (err_cnt != '1) begin
                     err_cnt <= err_cnt + ERRW'(1);
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_gray_rx_decoder.sv
// tb/tb_gray_rx_decoder.sv - directed self-checking bench for gray_rx_decoder
module tb_gray_rx_decoder;
   import gray_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] gray_in = '0;
   logic       gray_vld = 1'b0;

   logic [7:0] bin_out;
   logic       bin_vld, zero, wrap, step_err, locked;
   logic [7:0] err_cnt;

   logic [7:0] s_bin_out;
   logic       s_bin_vld, s_zero, s_wrap, s_step_err, s_locked;
   logic [1:0] s_err_cnt;

   int         n_assert = 0;
   int         n_fail = 0;
   string      tag = "reset";
   logic [7:0] pb = '0;
   logic [4:0] pf = '0;
   logic [7:0] pc = '0;

   always #5 clk = ~clk;

   gray_rx_decoder #(.CBITS(8), .LOCK_CNT(4), .ERRW(8)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .gray_in  (gray_in),
      .gray_vld (gray_vld),
      .bin_out  (bin_out),
      .bin_vld  (bin_vld),
      .zero     (zero),
      .wrap     (wrap),
      .step_err (step_err),
      .locked   (locked),
      .err_cnt  (err_cnt)
   );

   gray_rx_decoder #(.CBITS(8), .LOCK_CNT(4), .ERRW(2)) u_small (
      .clk      (clk),
      .rst      (rst),
      .gray_in  (gray_in),
      .gray_vld (gray_vld),
      .bin_out  (s_bin_out),
      .bin_vld  (s_bin_vld),
      .zero     (s_zero),
      .wrap     (s_wrap),
      .step_err (s_step_err),
      .locked   (s_locked),
      .err_cnt  (s_err_cnt)
   );

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
      end
   endtask

   // Expected values describe this step's sample; they are checked one step later.
   task automatic step(input logic v, input logic [7:0] g, input logic [7:0] eb,
                       input logic [4:0] ef, input logic [7:0] ec);
      gray_vld = v;
      gray_in  = g;
      @(posedge clk);
      @(negedge clk);
      chk({tag, " bin"},     32'(bin_out), 32'(pb));
      chk({tag, " flags"},   32'({bin_vld, zero, wrap, step_err, locked}), 32'(pf));
      chk({tag, " err_cnt"}, 32'(err_cnt), 32'(pc));
      chk({tag, " s.bin"},   32'(s_bin_out), 32'(pb));
      chk({tag, " s.flags"}, 32'({s_bin_vld, s_zero, s_wrap, s_step_err, s_locked}), 32'(pf));
      pb = eb;
      pf = ef;
      pc = ec;
   endtask

   task automatic do_reset();
      gray_vld = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("reset outputs", 32'({bin_out, bin_vld, zero, wrap, step_err, locked, err_cnt}), 32'd0);
      chk("reset small err_cnt", 32'(s_err_cnt), 32'd0);
      rst = 1'b0;
      pb  = '0;
      pf  = '0;
      pc  = '0;
   endtask

   initial begin
      logic [7:0]  r;
      logic [7:0]  b;
      logic [31:0] t;
      logic [1:0]  sat_tab [5];
      sat_tab = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      do_reset();

      tag = "t1";
      step(1, 8'h00, 8'd0, 5'b11000, 8'd0);
      step(1, 8'h01, 8'd1, 5'b10000, 8'd0);
      step(1, 8'h03, 8'd2, 5'b10000, 8'd0);
      step(1, 8'h02, 8'd3, 5'b10000, 8'd0);
      step(1, 8'h06, 8'd4, 5'b10001, 8'd0);
      step(1, 8'h07, 8'd5, 5'b10001, 8'd0);
      step(1, 8'h05, 8'd6, 5'b10001, 8'd0);
      step(1, 8'h04, 8'd7, 5'b10001, 8'd0);
      step(1, 8'h0C, 8'd8, 5'b10001, 8'd0);
      step(1, 8'h0D, 8'd9, 5'b10001, 8'd0);
      step(0, 8'h00, 8'd9, 5'b00001, 8'd0);
      step(0, 8'h00, 8'd9, 5'b00001, 8'd0);

      do_reset();
      tag = "t2";
      step(1, 8'h84, 8'd248, 5'b10000, 8'd0);
      step(1, 8'h85, 8'd249, 5'b10000, 8'd0);
      step(1, 8'h87, 8'd250, 5'b10000, 8'd0);
      step(1, 8'h86, 8'd251, 5'b10000, 8'd0);
      step(1, 8'h82, 8'd252, 5'b10001, 8'd0);
      step(1, 8'h83, 8'd253, 5'b10001, 8'd0);
      step(1, 8'h81, 8'd254, 5'b10001, 8'd0);
      step(1, 8'h80, 8'd255, 5'b10001, 8'd0);
      step(1, 8'h00, 8'd0,   5'b11101, 8'd0);
      step(1, 8'h01, 8'd1,   5'b10001, 8'd0);

      tag = "t3";
      step(1, 8'h03, 8'd2,  5'b10001, 8'd0);
      step(1, 8'h02, 8'd3,  5'b10001, 8'd0);
      step(1, 8'h06, 8'd4,  5'b10001, 8'd0);
      step(1, 8'h07, 8'd5,  5'b10001, 8'd0);
      step(1, 8'h05, 8'd6,  5'b10001, 8'd0);
      step(1, 8'h04, 8'd7,  5'b10001, 8'd0);
      step(1, 8'h0C, 8'd8,  5'b10001, 8'd0);
      step(1, 8'h0D, 8'd9,  5'b10001, 8'd0);
      step(1, 8'h0F, 8'd10, 5'b10001, 8'd0);
      step(1, 8'h0A, 8'd12, 5'b10010, 8'd1);
      step(1, 8'h0B, 8'd13, 5'b10000, 8'd1);
      step(1, 8'h09, 8'd14, 5'b10000, 8'd1);
      step(1, 8'h08, 8'd15, 5'b10000, 8'd1);
      step(1, 8'h18, 8'd16, 5'b10001, 8'd1);
      step(0, 8'h00, 8'd16, 5'b00001, 8'd1);
      step(0, 8'h00, 8'd16, 5'b00001, 8'd1);
      chk("t3 small err_cnt", 32'(s_err_cnt), 32'd1);

      do_reset();
      tag = "t4";
      step(1, 8'h05, 8'd6,  5'b10000, 8'd0);
      step(1, 8'h04, 8'd7,  5'b10000, 8'd0);
      step(1, 8'h0C, 8'd8,  5'b10000, 8'd0);
      step(1, 8'h0D, 8'd9,  5'b10000, 8'd0);
      step(1, 8'h0F, 8'd10, 5'b10001, 8'd0);
      for (int i = 0; i < 3; i++) step(1, 8'h0E, 8'd11, 5'b10001, 8'd0);
      for (int i = 0; i < 5; i++) step(0, 8'h00, 8'd11, 5'b00001, 8'd0);
      step(1, 8'h0A, 8'd12, 5'b10001, 8'd0);
      step(0, 8'h00, 8'd12, 5'b00001, 8'd0);

      tag = "t5";
      gray_vld = 1'b1;
      gray_in  = 8'h0D;
      @(posedge clk);
      @(negedge clk);
      gray_vld = 1'b0;
      rst      = 1'b1;
      #1;
      chk("t5 async clear", 32'({bin_out, bin_vld, zero, wrap, step_err, locked, err_cnt}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      pb  = '0;
      pf  = '0;
      pc  = '0;
      step(0, 8'h00, 8'h00, 5'b00000, 8'd0);
      step(0, 8'h00, 8'h00, 5'b00000, 8'd0);
      step(1, 8'h55, 8'h66, 5'b10000, 8'd0);
      step(0, 8'h00, 8'h66, 5'b00000, 8'd0);
      step(0, 8'h00, 8'h66, 5'b00000, 8'd0);

      tag = "t6";
      r = 8'h66;
      for (int k = 0; k < 5; k++) begin
         for (int j = 1; j <= 4; j++) begin
            b = r + 8'(j);
            t = bin2gray(32'(b));
            step(1, t[7:0], b, (j == 4) ? 5'b10001 : 5'b10000, 8'(k));
         end
         b = r + 8'd54;
         t = bin2gray(32'(b));
         step(1, t[7:0], b, 5'b10010, 8'(k + 1));
         step(0, 8'h00, b, 5'b00000, 8'(k + 1));
         chk("t6 small err_cnt", 32'(s_err_cnt), 32'(sat_tab[k]));
         r = b;
      end
      step(0, 8'h00, r, 5'b00000, 8'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
